sigmoid_lut_loader: RTL and testbench

- Runtime-writable sigmoid lookup table, the writer side of the neuron's activation LUT.
- Table entries arrive over a valid/ready stream with an auto-incrementing address and are written into on-chip RAM.
- Once the table is fully loaded, the block serves signed-input lookups using the same offset mapping as the static activation ROM.
- Sits between the config/DMA path and the neuron activation stage, so sigmoid contents can be replaced without regenerating .mif files.

---
 rtl/sig_lut_pkg.sv | 18 +
 rtl/sig_lut_ram.sv | 34 +++
 rtl/sigmoid_lut_loader.sv | 94 +++++++++
 tb/tb_sigmoid_lut_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_lut_pkg.sv
// Shared definitions for the runtime-writable sigmoid LUT: loader state encoding,
// checksum width and the signed-input address mapping.
package sig_lut_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned CHECKSUM_W = 16;

   // Two's-complement x becomes an offset address by flipping its sign bit.
   function automatic logic map_msb(input logic x_msb);
      return ~x_msb;
   endfunction

endpackage

// File: rtl/sig_lut_ram.sv
// Simple dual-port table RAM: one write port, one registered read port.
// Contents are never reset; only the read register is.
module sig_lut_ram #(
   parameter int unsigned AddrW = 10,
   parameter int unsigned DataW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AddrW-1:0] waddr,
   input  logic [DataW-1:0] wdata,
   input  logic             re,
   input  logic [AddrW-1:0] raddr,
   output logic [DataW-1:0] rdata
);

   logic [DataW-1:0] mem [0:(1<<AddrW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register holds its value on cycles without a read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sigmoid_lut_loader.sv
// Streams a sigmoid table into RAM, then serves 1-cycle signed lookups.
// Optional load checksum output is enabled by defining SIG_LUT_CHECKSUM_EN.
module sigmoid_lut_loader
   import sig_lut_pkg::*;
#(
   parameter int unsigned inWidth   = 10,
   parameter int unsigned dataWidth = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_start,
   input  logic                 wr_valid,
   input  logic [dataWidth-1:0] wr_data,
   output logic                 wr_ready,
   output logic                 load_done,
   output logic                 table_ready,
   input  logic [inWidth-1:0]   x,
   input  logic                 x_valid,
   output logic [dataWidth-1:0] out,
`ifdef SIG_LUT_CHECKSUM_EN
   output logic                 out_valid,
   output logic [CHECKSUM_W-1:0] checksum
`else
   output logic                 out_valid
`endif
);

   localparam logic [inWidth-1:0] LAST = '1;

   state_t             state;
   logic [inWidth-1:0] cnt;
   logic [inWidth-1:0] rd_addr;
   logic               xfer;
   logic               ram_we;
   logic               ram_re;

   assign xfer    = wr_valid && wr_ready;
   // A transfer coinciding with load_start is discarded.
   assign ram_we  = xfer && !load_start;
   assign ram_re  = x_valid && table_ready;
   assign rd_addr = {map_msb(x[inWidth-1]), x[inWidth-2:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         wr_ready    <= 1'b0;
         load_done   <= 1'b0;
         table_ready <= 1'b0;
         out_valid   <= 1'b0;
`ifdef SIG_LUT_CHECKSUM_EN
         checksum    <= '0;
`endif
      end else begin
         load_done <= 1'b0;
         out_valid <= ram_re;
         if (load_start) begin
            state       <= LOAD;
            cnt         <= '0;
            wr_ready    <= 1'b1;
            table_ready <= 1'b0;
`ifdef SIG_LUT_CHECKSUM_EN
            checksum    <= '0;
`endif
         end else if (state == LOAD && xfer) begin
            cnt <= cnt + 1'b1;
`ifdef SIG_LUT_CHECKSUM_EN
            checksum <= checksum + CHECKSUM_W'(wr_data);
`endif
            if (cnt == LAST) begin
               state       <= DONE;
               wr_ready    <= 1'b0;
               load_done   <= 1'b1;
               table_ready <= 1'b1;
            end
         end
      end
   end

   sig_lut_ram #(
      .AddrW (inWidth),
      .DataW (dataWidth)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .waddr (cnt),
      .wdata (wr_data),
      .re    (ram_re),
      .raddr (rd_addr),
      .rdata (out)
   );

endmodule

// File: tb/tb_sigmoid_lut_loader.sv
// Scoreboard bench for sigmoid_lut_loader: lookups push expected values, a monitor
// pops and compares on each out_valid; loader status is checked directly.
module tb_sigmoid_lut_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic        wr_valid;
   logic [15:0] wr_data;
   logic        wr_ready;
   logic        load_done;
   logic        table_ready;
   logic [9:0]  x;
   logic        x_valid;
   logic [15:0] out;
   logic        out_valid;
`ifdef SIG_LUT_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned done_cnt = 0;
   int unsigned xfer_cnt = 0;
   logic [15:0] exp_q [$];

   always #5 clk = ~clk;

   sigmoid_lut_loader #(
      .inWidth   (10),
      .dataWidth (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .load_done   (load_done),
      .table_ready (table_ready),
      .x           (x),
      .x_valid     (x_valid),
      .out         (out),
`ifdef SIG_LUT_CHECKSUM_EN
      .checksum    (checksum),
`endif
      .out_valid   (out_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (load_done) done_cnt++;
      if (wr_valid && wr_ready && !load_start) xfer_cnt++;
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("lookup_out", 32'(out), 32'(e));
         end
      end
   end

   task automatic pulse_load(input logic hold_valid, input logic [15:0] hold_data);
      @(posedge clk); #1;
      load_start = 1'b1;
      wr_valid   = hold_valid;
      wr_data    = hold_data;
      @(posedge clk); #1;
      load_start = 1'b0;
      wr_valid   = 1'b0;
   endtask

   // mode 0: data=i, 1: data=1023-i, 2: data=val. Leaves time at #1 after last edge.
   task automatic stream(input int n, input bit gaps, input int mode, input logic [15:0] val);
      int i = 0;
      int budget = 0;
      logic acc;
      while (i < n && budget < 20000) begin
         wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         wr_data  = (mode == 0) ? 16'(i) : (mode == 1) ? 16'(1023 - i) : val;
         @(negedge clk);
         acc = wr_valid && wr_ready;
         @(posedge clk); #1;
         if (acc) i++;
         budget++;
      end
      wr_valid = 1'b0;
      if (budget >= 20000) check("stream_timeout", 32'(i), 32'(n));
   endtask

   task automatic lookup(input logic [9:0] xv, input bit expect_valid, input logic [15:0] ev);
      @(posedge clk); #1;
      x       = xv;
      x_valid = 1'b1;
      if (expect_valid) exp_q.push_back(ev);
   endtask

   task automatic lookup_end();
      @(posedge clk); #1;
      x_valid = 1'b0;
   endtask

   task automatic check_load_complete(input string tag);
      @(negedge clk);
      check({tag, "_load_done"}, 32'(load_done), 32'd1);
      check({tag, "_table_ready"}, 32'(table_ready), 32'd1);
      check({tag, "_wr_ready_low"}, 32'(wr_ready), 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse_once"}, done_cnt, 32'd1);
   endtask

   initial begin
      rst = 1'b1; load_start = 1'b0; wr_valid = 1'b0; wr_data = '0;
      x = 10'd0; x_valid = 1'b1;

      // Reset with lookups requested
      repeat (2) begin
         @(negedge clk);
         check("rst_out", 32'(out), 32'd0);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_table_ready", 32'(table_ready), 32'd0);
         check("rst_wr_ready", 32'(wr_ready), 32'd0);
         check("rst_load_done", 32'(load_done), 32'd0);
      end
      @(posedge clk); #1; rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("idle_out_valid", 32'(out_valid), 32'd0);
         check("idle_table_ready", 32'(table_ready), 32'd0);
      end
      @(posedge clk); #1; x_valid = 1'b0;

      // Full ramp load, no gaps
      done_cnt = 0; xfer_cnt = 0;
      pulse_load(1'b0, 16'h0);
      stream(1024, 1'b0, 0, 16'h0);
      check_load_complete("ramp");
      check("ramp_xfers", xfer_cnt, 32'd1024);
`ifdef SIG_LUT_CHECKSUM_EN
      check("ramp_checksum", 32'(checksum), 32'h0000FE00);
`endif

      // Signed lookups back to back: -512, 0, 511, -1
      lookup(10'h200, 1'b1, 16'd0);
      lookup(10'h000, 1'b1, 16'd512);
      lookup(10'h1FF, 1'b1, 16'd1023);
      lookup(10'h3FF, 1'b1, 16'd511);
      lookup_end();
      repeat (2) @(posedge clk);

      // Random backpressure with a reversed ramp, then stray writes while DONE
      done_cnt = 0; xfer_cnt = 0;
      pulse_load(1'b0, 16'h0);
      stream(1024, 1'b1, 1, 16'h0);
      check_load_complete("gaps");
      wr_valid = 1'b1; wr_data = 16'hFFFF;
      repeat (4) @(posedge clk);
      #1; wr_valid = 1'b0;
      check("gaps_xfers", xfer_cnt, 32'd1024);
`ifdef SIG_LUT_CHECKSUM_EN
      check("gaps_checksum", 32'(checksum), 32'h0000FE00);
`endif
      for (int a = 0; a < 1024; a++) begin
         logic [9:0] av;
         av = 10'(a);
         lookup(av ^ 10'h200, 1'b1, 16'(1023 - a));
      end
      lookup_end();
      repeat (2) @(posedge clk);

      // Restart mid-load after 300 transfers
      done_cnt = 0;
      pulse_load(1'b0, 16'h0);
      stream(300, 1'b0, 0, 16'h0);
      pulse_load(1'b1, 16'hBEEF);
      @(negedge clk);
      check("restart_table_ready", 32'(table_ready), 32'd0);
      check("restart_wr_ready", 32'(wr_ready), 32'd1);
      check("restart_no_done", done_cnt, 32'd0);
      lookup(10'h000, 1'b0, 16'h0);
      lookup_end();
      @(negedge clk);
      check("restart_lookup_invalid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      stream(1024, 1'b0, 2, 16'h00AA);
      check_load_complete("reload");
`ifdef SIG_LUT_CHECKSUM_EN
      check("reload_checksum", 32'(checksum), 32'h0000A800);
`endif
      for (int a = 0; a < 1024; a += 73) lookup(10'(a), 1'b1, 16'h00AA);
      lookup(10'h3FF, 1'b1, 16'h00AA);
      lookup_end();
      repeat (2) @(posedge clk);

      // Reset mid-load at transfer 700
      done_cnt = 0;
      pulse_load(1'b0, 16'h0);
      stream(700, 1'b0, 2, 16'h1234);
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("midrst_wr_ready", 32'(wr_ready), 32'd0);
      check("midrst_table_ready", 32'(table_ready), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      xfer_cnt = 0;
      wr_valid = 1'b1; wr_data = 16'h5555;
      lookup(10'h000, 1'b0, 16'h0);
      lookup_end();
      @(negedge clk);
      check("midrst_lookup_invalid", 32'(out_valid), 32'd0);
      check("midrst_no_idle_writes", xfer_cnt, 32'd0);
      @(posedge clk); #1; wr_valid = 1'b0;
      done_cnt = 0;
      pulse_load(1'b0, 16'h0);
      stream(1024, 1'b0, 0, 16'h0);
      check_load_complete("final");
      lookup(10'h200, 1'b1, 16'd0);
      lookup(10'h1FF, 1'b1, 16'd1023);
      lookup(10'h001, 1'b1, 16'd513);
      lookup_end();
      repeat (3) @(posedge clk);

      @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
